frequency_bin_stream: RTL and testbench
=======================================

FREQUENCY_BIN_STREAM -- requirements
Module: classifier_helpers_frequency_bin_stream

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32, width of sampling frequency and bin values.
REQ-002 SHALL have parameter N_SAMPLES, default 16, number of bins generated per request; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have ports recv_val (input, 1) and recv_rdy (output, 1): request handshake.
REQ-006 SHALL have port recv_fs, input, BIT_WIDTH, unsigned sampling frequency.
REQ-007 SHALL have port recv_mode, input, 1: 0 = half-band spacing fs/(2N), 1 = full-band spacing fs/N.
REQ-008 SHALL have ports send_val (output, 1) and send_rdy (input, 1): bin stream handshake.
REQ-009 SHALL have port send_msg, output, BIT_WIDTH, current bin frequency.
REQ-010 SHALL have port send_idx, output, $clog2(N_SAMPLES), current bin index.
REQ-011 SHALL have port send_last, output, 1, high with bin index N_SAMPLES-1.

Function
REQ-012 SHALL use FSM states IDLE and GEN; IDLE: recv_rdy=1, send_val=0; GEN: recv_rdy=0, send_val=1.
REQ-013 SHALL, in IDLE on recv_val&&recv_rdy, latch recv_fs and recv_mode, clear accumulator and index, enter GEN.
REQ-014 SHALL present bin 0 on send_* the cycle after request acceptance (latency 1).
REQ-015 SHALL compute bins without multipliers: accumulator width $clog2(N_SAMPLES)+BIT_WIDTH, incremented by latched fs on each send handshake.
REQ-016 SHALL drive send_msg = low BIT_WIDTH bits of (accumulator >> ($clog2(N_SAMPLES)+1-mode)), i.e. floor(i*fs/(2N)) in mode 0, floor(i*fs/N) in mode 1.
REQ-017 SHALL hold send_msg, send_idx, send_last stable while send_val=1 and send_rdy=0.
REQ-018 SHALL, on send handshake with index < N_SAMPLES-1, increment index and accumulator and stay in GEN.
REQ-019 SHALL, on send handshake with index = N_SAMPLES-1, return to IDLE; recv_rdy high next cycle (no back-to-back accept in the same cycle).
REQ-020 SHALL ignore recv_val and recv_fs changes while in GEN.
REQ-021 SHALL never overflow the accumulator: (N_SAMPLES-1)*fs_max fits the chosen width.

Reset
REQ-022 SHALL, on reset assertion (asynchronous, any state, including mid-stream), enter IDLE with accumulator, index, latched fs and mode at 0, send_val=0, send_msg=0, send_idx=0, send_last=0, recv_rdy=1 after release.
REQ-023 SHALL discard any partially emitted stream on reset; no resumption.

Configuration
REQ-024 SHALL support macro CLASSIFIER_FREQ_BIN_PARALLEL_EN; when defined, add outputs frequency_out (N_SAMPLES*BIT_WIDTH) and frequency_out_val (1).
REQ-025 SHALL, with the macro defined, write bin i into frequency_out slice (N_SAMPLES-1-i) on its send handshake and assert frequency_out_val the cycle after the last handshake, clearing it on next request acceptance; reset clears both to 0.
REQ-026 SHALL, without the macro, have no such ports and no bin storage registers.

Structure
REQ-027 SHALL place the FSM state enum and the mode encoding constants (MODE_HALF=0, MODE_FULL=1) in shared package classifier_helpers_pkg.
REQ-028 SHALL be a single module; no sub-module required.

Verification
REQ-029 BIT_WIDTH=32, N=16, fs=48000, mode 0, send_rdy=1 -> bins 0,1500,...,22500 on 16 consecutive cycles, send_last only with idx 15.
REQ-030 Same with mode 1 -> bins 0,3000,...,45000.
REQ-031 fs=1000, mode 0, send_rdy toggled randomly -> bins floor(i*1000/32): 0,31,62,93,...,468; stable during stalls.
REQ-032 fs=32'hFFFFFFFF, mode 0 -> bin 15 = 32'h77FFFFFF (floor(15*fs/32)), no overflow.
REQ-033 reset asserted after bin 5 accepted -> send_val=0 immediately, recv_rdy=1 after release; new request restarts at bin 0.
REQ-034 with CLASSIFIER_FREQ_BIN_PARALLEL_EN, fs=48000 mode 0 -> frequency_out_val high one cycle after bin 15; slice 15 = 0, slice 0 = 22500.

Source files
------------

// File: rtl/classifier_helpers_pkg.sv
// Shared FSM state and mode encodings for the classifier helper blocks.
package classifier_helpers_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } fbs_state_t;

  localparam logic MODE_HALF = 1'b0;
  localparam logic MODE_FULL = 1'b1;

endpackage

// File: rtl/frequency_bin_stream.sv
// Streams N_SAMPLES bin frequencies i*fs/(2N) or i*fs/N using a shift-add accumulator.
// Optional parallel bin capture enabled by CLASSIFIER_FREQ_BIN_PARALLEL_EN.
module frequency_bin_stream
  import classifier_helpers_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned N_SAMPLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  input  logic [BIT_WIDTH-1:0]         recv_fs,
  input  logic                         recv_mode,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic [BIT_WIDTH-1:0]         send_msg,
  output logic [$clog2(N_SAMPLES)-1:0] send_idx,
  output logic                         send_last
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
  ,
  output logic [N_SAMPLES*BIT_WIDTH-1:0] frequency_out,
  output logic                           frequency_out_val
`endif
);

  localparam int unsigned IW = $clog2(N_SAMPLES);
  localparam int unsigned AW = IW + BIT_WIDTH;

  fbs_state_t           state, state_nxt;
  logic [AW-1:0]        acc;
  logic [BIT_WIDTH-1:0] fs_q;
  logic                 mode_q;
  logic [IW-1:0]        idx;
  logic                 accept, fire, at_last;

  assign accept  = recv_val && recv_rdy;
  assign fire    = send_val && send_rdy;
  assign at_last = (idx == IW'(N_SAMPLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    recv_rdy  = 1'b0;
    send_val  = 1'b0;
    case (state)
      IDLE: begin
        recv_rdy = 1'b1;
        if (recv_val) state_nxt = GEN;
      end
      GEN: begin
        send_val = 1'b1;
        if (send_rdy && at_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // acc/idx are cleared after the final bin so IDLE always presents bin 0 values
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      idx    <= '0;
      fs_q   <= '0;
      mode_q <= MODE_HALF;
    end else if (accept) begin
      acc    <= '0;
      idx    <= '0;
      fs_q   <= recv_fs;
      mode_q <= recv_mode;
    end else if (fire) begin
      if (at_last) begin
        acc <= '0;
        idx <= '0;
      end else begin
        acc <= acc + AW'(fs_q);
        idx <= idx + 1'b1;
      end
    end
  end

  // Dividing by N (or 2N) is a fixed right shift of the accumulator
  always_comb begin
    if (mode_q == MODE_FULL) send_msg = acc[IW +: BIT_WIDTH];
    else                     send_msg = {1'b0, acc[IW+1 +: BIT_WIDTH-1]};
  end

  assign send_idx  = idx;
  assign send_last = (state == GEN) && at_last;

`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frequency_out     <= '0;
      frequency_out_val <= 1'b0;
    end else begin
      if (accept) frequency_out_val <= 1'b0;
      if (fire) begin
        for (int unsigned s = 0; s < N_SAMPLES; s++) begin
          if (idx == IW'(N_SAMPLES - 1 - s))
            frequency_out[s*BIT_WIDTH +: BIT_WIDTH] <= send_msg;
        end
        if (at_last) frequency_out_val <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frequency_bin_stream.sv
// Directed bench for frequency_bin_stream; also covers CLASSIFIER_FREQ_BIN_PARALLEL_EN when defined.
module tb_frequency_bin_stream;

  localparam int unsigned BW = 32;
  localparam int unsigned N  = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          recv_val;
  logic          recv_rdy;
  logic [BW-1:0] recv_fs;
  logic          recv_mode;
  logic          send_val;
  logic          send_rdy;
  logic [BW-1:0] send_msg;
  logic [3:0]    send_idx;
  logic          send_last;
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
  logic [N*BW-1:0] frequency_out;
  logic            frequency_out_val;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frequency_bin_stream #(.BIT_WIDTH(BW), .N_SAMPLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .recv_val  (recv_val),
    .recv_rdy  (recv_rdy),
    .recv_fs   (recv_fs),
    .recv_mode (recv_mode),
    .send_val  (send_val),
    .send_rdy  (send_rdy),
    .send_msg  (send_msg),
    .send_idx  (send_idx),
    .send_last (send_last)
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
    ,
    .frequency_out     (frequency_out),
    .frequency_out_val (frequency_out_val)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request; returns after the accepting edge
  task automatic request(input logic [BW-1:0] fs, input logic mode);
    chk("req_rdy", {63'd0, recv_rdy}, 64'd1);
    recv_val  = 1'b1;
    recv_fs   = fs;
    recv_mode = mode;
    tick();
    recv_val  = 1'b0;
    recv_fs   = 32'hDEAD_BEEF;
    recv_mode = ~mode;
  endtask

  logic [BW-1:0] exp_msg;
  int            stalls;

  initial begin
    reset     = 1'b1;
    recv_val  = 1'b0;
    recv_fs   = '0;
    recv_mode = 1'b0;
    send_rdy  = 1'b0;
    #1;
    chk("rst_send_val", {63'd0, send_val}, 64'd0);
    chk("rst_send_msg", {32'd0, send_msg}, 64'd0);
    chk("rst_send_idx", {60'd0, send_idx}, 64'd0);
    chk("rst_send_last", {63'd0, send_last}, 64'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    chk("rst_recv_rdy", {63'd0, recv_rdy}, 64'd1);

    // fs=48000 half band, no backpressure: bins i*1500
    send_rdy = 1'b1;
    request(32'd48000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("h_val", {63'd0, send_val}, 64'd1);
      chk("h_rdy", {63'd0, recv_rdy}, 64'd0);
      chk("h_msg", {32'd0, send_msg}, 64'(i * 1500));
      chk("h_idx", {60'd0, send_idx}, 64'(i));
      chk("h_last", {63'd0, send_last}, (i == 15) ? 64'd1 : 64'd0);
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
      chk("p_val_low", {63'd0, frequency_out_val}, 64'd0);
`endif
      tick();
    end
    chk("h_done_val", {63'd0, send_val}, 64'd0);
    chk("h_done_rdy", {63'd0, recv_rdy}, 64'd1);
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
    chk("p_val_high", {63'd0, frequency_out_val}, 64'd1);
    chk("p_slice15", {32'd0, frequency_out[15*BW +: BW]}, 64'd0);
    chk("p_slice0", {32'd0, frequency_out[0 +: BW]}, 64'd22500);
    chk("p_slice8", {32'd0, frequency_out[8*BW +: BW]}, 64'd10500);
`endif

    // fs=48000 full band: bins i*3000
    request(32'd48000, 1'b1);
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
    chk("p_val_cleared", {63'd0, frequency_out_val}, 64'd0);
`endif
    for (int i = 0; i < 16; i++) begin
      chk("f_msg", {32'd0, send_msg}, 64'(i * 3000));
      chk("f_idx", {60'd0, send_idx}, 64'(i));
      chk("f_last", {63'd0, send_last}, (i == 15) ? 64'd1 : 64'd0);
      tick();
    end
    chk("f_done_val", {63'd0, send_val}, 64'd0);

    // fs=1000 half band with random stalls: floor(i*1000/32)
    send_rdy = 1'b0;
    request(32'd1000, 1'b0);
    for (int i = 0; i < 16; i++) begin
      exp_msg = BW'((i * 1000) / 32);
      stalls  = $urandom_range(0, 2);
      send_rdy = 1'b0;
      for (int s = 0; s < stalls; s++) begin
        tick();
        chk("s_hold_val", {63'd0, send_val}, 64'd1);
        chk("s_hold_msg", {32'd0, send_msg}, {32'd0, exp_msg});
        chk("s_hold_idx", {60'd0, send_idx}, 64'(i));
      end
      send_rdy = 1'b1;
      chk("s_msg", {32'd0, send_msg}, {32'd0, exp_msg});
      chk("s_last", {63'd0, send_last}, (i == 15) ? 64'd1 : 64'd0);
      tick();
    end
    chk("s_done_rdy", {63'd0, recv_rdy}, 64'd1);

    // Full-scale fs: no accumulator overflow at bin 15
    request(32'hFFFF_FFFF, 1'b0);
    chk("o_bin0", {32'd0, send_msg}, 64'd0);
    tick();
    chk("o_bin1", {32'd0, send_msg}, 64'h07FF_FFFF);
    repeat (14) tick();
    chk("o_idx15", {60'd0, send_idx}, 64'd15);
    chk("o_bin15", {32'd0, send_msg}, 64'h77FF_FFFF);
    tick();

    // Reset mid-stream after bin 5 accepted
    request(32'd48000, 1'b0);
    repeat (6) tick();
    chk("m_idx6", {60'd0, send_idx}, 64'd6);
    reset = 1'b1;
    #1;
    chk("m_val", {63'd0, send_val}, 64'd0);
    chk("m_msg", {32'd0, send_msg}, 64'd0);
    chk("m_idx", {60'd0, send_idx}, 64'd0);
`ifdef CLASSIFIER_FREQ_BIN_PARALLEL_EN
    chk("m_pout", {63'd0, |frequency_out}, 64'd0);
`endif
    tick();
    reset = 1'b0;
    tick();
    chk("m_rdy", {63'd0, recv_rdy}, 64'd1);
    chk("m_idle_val", {63'd0, send_val}, 64'd0);
    request(32'd48000, 1'b1);
    chk("m_restart_idx", {60'd0, send_idx}, 64'd0);
    chk("m_restart_msg", {32'd0, send_msg}, 64'd0);
    tick();
    chk("m_restart_bin1", {32'd0, send_msg}, 64'd3000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
